// File: rtl/i2c_slv_reg_bank.sv
// I2C slave register bank: address match, pointer load, register write/read sequencing.
// Define I2C_REG_WRAP_EN to wrap the pointer at REG_NUM-1; by default it saturates and extra writes are NACKed.
module i2c_slv_reg_bank #(
    parameter int                 DATA_SZ  = 8,
    parameter logic [DATA_SZ-2:0] SLV_ADDR = 7'h3C,
    parameter int                 REG_NUM  = 16,
    localparam int                PTR_SZ   = $clog2(REG_NUM)
) (
    input  logic               CLK,
    input  logic               RST_n,
    input  logic               I_BUSY,
    input  logic [DATA_SZ-2:0] I_ADDR_SLV,
    input  logic               I_RW,
    input  logic [DATA_SZ-1:0] I_DATA_RD,
    input  logic               I_DATA_VL,
    input  logic               I_ACK_MSTR,
    output logic               O_ACK,
    output logic [DATA_SZ-1:0] O_DATA_WR,
    output logic               O_WR_STB,
    output logic [PTR_SZ-1:0]  O_WR_ADDR,
    output logic [DATA_SZ-1:0] O_WR_DATA,
    output logic [PTR_SZ-1:0]  O_PTR
);

    // IDLE wait for bus | ADDR address byte | PTR pointer byte | WR data bytes | RD transmit | SKIP ignore rest
    typedef enum logic [2:0] {IDLE, ADDR, PTR, WR, RD, SKIP} state_t;

    state_t             r_state, w_state_nxt;
    logic               r_busy_d;
    logic [PTR_SZ-1:0]  r_ptr, w_ptr_nxt, w_ptr_inc;
    logic [DATA_SZ-1:0] r_regs [REG_NUM];
    logic [DATA_SZ-1:0] r_data_wr;
    logic               r_wr_stb;
    logic [PTR_SZ-1:0]  r_wr_addr;
    logic [DATA_SZ-1:0] r_wr_data;
    logic               w_wr_en;
    logic               w_match;
    logic               w_busy_rise;
    logic               w_busy_fall;

    assign w_match     = (I_ADDR_SLV == SLV_ADDR);
    assign w_busy_rise = I_BUSY & ~r_busy_d;
    assign w_busy_fall = ~I_BUSY & r_busy_d;

`ifdef I2C_REG_WRAP_EN
    assign w_ptr_inc = r_ptr + PTR_SZ'(1);
`else
    localparam logic [PTR_SZ-1:0] PTR_MAX = PTR_SZ'(REG_NUM - 1);
    logic r_full, w_full_nxt;

    assign w_ptr_inc = (r_ptr == PTR_MAX) ? r_ptr : r_ptr + PTR_SZ'(1);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) r_full <= 1'b0;
        else        r_full <= w_full_nxt;
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_wr_en     = 1'b0;
        O_ACK       = 1'b0;
`ifndef I2C_REG_WRAP_EN
        w_full_nxt  = r_full;
`endif
        case (r_state)
            IDLE: begin
                O_ACK = w_match;
                if (w_busy_rise) w_state_nxt = ADDR;
            end
            ADDR: begin
                O_ACK = w_match;
                if (I_DATA_VL) begin
                    if (!w_match)  w_state_nxt = SKIP;
                    else if (I_RW) w_state_nxt = RD;
                    else           w_state_nxt = PTR;
                end
            end
            PTR: begin
                O_ACK = 1'b1;
                if (I_DATA_VL) begin
                    w_ptr_nxt   = I_DATA_RD[PTR_SZ-1:0];
                    w_state_nxt = WR;
`ifndef I2C_REG_WRAP_EN
                    w_full_nxt  = 1'b0;
`endif
                end
            end
            WR: begin
`ifdef I2C_REG_WRAP_EN
                O_ACK = 1'b1;
                if (I_DATA_VL) begin
                    w_wr_en   = 1'b1;
                    w_ptr_nxt = w_ptr_inc;
                end
`else
                O_ACK = ~r_full;
                if (I_DATA_VL && !r_full) begin
                    w_wr_en   = 1'b1;
                    w_ptr_nxt = w_ptr_inc;
                    if (r_ptr == PTR_MAX) w_full_nxt = 1'b1;
                end
`endif
            end
            RD: begin
                if (I_DATA_VL) begin
                    w_ptr_nxt = w_ptr_inc;
                    if (I_ACK_MSTR) w_state_nxt = SKIP;
                end
            end
            SKIP: ;
            default: w_state_nxt = IDLE;
        endcase
        // the byte in flight is still honoured above before dropping back to idle
        if (w_busy_fall) w_state_nxt = IDLE;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state   <= IDLE;
            r_busy_d  <= 1'b1;
            r_ptr     <= '0;
            r_data_wr <= '0;
            r_wr_stb  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            for (int i = 0; i < REG_NUM; i++) r_regs[i] <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_busy_d  <= I_BUSY;
            r_ptr     <= w_ptr_nxt;
            r_data_wr <= r_regs[r_ptr];
            r_wr_stb  <= w_wr_en;
            if (w_wr_en) begin
                r_regs[r_ptr] <= I_DATA_RD;
                r_wr_addr     <= r_ptr;
                r_wr_data     <= I_DATA_RD;
            end
        end
    end

    assign O_DATA_WR = r_data_wr;
    assign O_WR_STB  = r_wr_stb;
    assign O_WR_ADDR = r_wr_addr;
    assign O_WR_DATA = r_wr_data;
    assign O_PTR     = r_ptr;

endmodule

// File: tb/tb_i2c_slv_reg_bank.sv
// Scoreboard bench for i2c_slv_reg_bank: expected writes/reads are queued by the driver and
// checked by a monitor on O_WR_STB pulses and read-sample points.
module tb_i2c_slv_reg_bank;

    logic       CLK = 1'b0;
    logic       RST_n;
    logic       I_BUSY, I_RW, I_DATA_VL, I_ACK_MSTR;
    logic [6:0] I_ADDR_SLV;
    logic [7:0] I_DATA_RD;
    logic       O_ACK, O_WR_STB;
    logic [7:0] O_DATA_WR, O_WR_DATA;
    logic [3:0] O_WR_ADDR, O_PTR;

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        exp_wr[$];
    logic [7:0] exp_rd[$];
    logic       rd_smp = 1'b0;
    int         n_vec  = 0;
    int         n_err  = 0;

    i2c_slv_reg_bank dut (
        .CLK(CLK), .RST_n(RST_n), .I_BUSY(I_BUSY), .I_ADDR_SLV(I_ADDR_SLV), .I_RW(I_RW),
        .I_DATA_RD(I_DATA_RD), .I_DATA_VL(I_DATA_VL), .I_ACK_MSTR(I_ACK_MSTR),
        .O_ACK(O_ACK), .O_DATA_WR(O_DATA_WR), .O_WR_STB(O_WR_STB), .O_WR_ADDR(O_WR_ADDR),
        .O_WR_DATA(O_WR_DATA), .O_PTR(O_PTR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (O_WR_STB === 1'b1) begin
            if (exp_wr.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h expected no write at %0t",
                         O_WR_ADDR, O_WR_DATA, $time);
            end else begin
                wr_t e;
                e = exp_wr.pop_front();
                chk("wr_addr", 32'(O_WR_ADDR), 32'(e.a));
                chk("wr_data", 32'(O_WR_DATA), 32'(e.d));
            end
        end
        if (rd_smp) begin
            if (exp_rd.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rd_unexpected: got 0x%0h expected nothing queued", O_DATA_WR);
            end else begin
                chk("rd_data", 32'(O_DATA_WR), 32'(exp_rd.pop_front()));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic start(input logic [6:0] addr, input logic rw);
        I_ADDR_SLV = addr;
        I_RW       = rw;
        I_BUSY     = 1'b1;
        tick(1);
    endtask

    task automatic send(input logic [7:0] d, input logic am);
        I_DATA_RD  = d;
        I_ACK_MSTR = am;
        I_DATA_VL  = 1'b1;
        tick(1);
        I_DATA_VL  = 1'b0;
        tick(1);
    endtask

    task automatic stop();
        I_BUSY = 1'b0;
        tick(2);
    endtask

    task automatic rd_chk(input logic [7:0] e);
        exp_rd.push_back(e);
        rd_smp = 1'b1;
        tick(1);
        rd_smp = 1'b0;
    endtask

    task automatic set_ptr(input logic [7:0] p);
        start(7'h3C, 1'b0);
        send({7'h3C, 1'b0}, 1'b0);
        send(p, 1'b0);
        stop();
    endtask

    initial begin
        RST_n = 1'b0; I_BUSY = 1'b0; I_RW = 1'b0; I_DATA_VL = 1'b0; I_ACK_MSTR = 1'b0;
        I_ADDR_SLV = 7'h00; I_DATA_RD = 8'h00;
        tick(2);
        chk("rst_ptr", 32'(O_PTR), 0);
        chk("rst_ack_nomatch", 32'(O_ACK), 0);
        RST_n = 1'b1;
        tick(2);

        // write 0x3C/W ptr 2, A5, 5A
        start(7'h3C, 1'b0);
        chk("ack_addr", 32'(O_ACK), 1);
        send({7'h3C, 1'b0}, 1'b0);
        chk("ack_ptr", 32'(O_ACK), 1);
        send(8'h02, 1'b0);
        chk("ack_wr0", 32'(O_ACK), 1);
        exp_wr.push_back('{a: 4'd2, d: 8'hA5});
        send(8'hA5, 1'b0);
        chk("ack_wr1", 32'(O_ACK), 1);
        exp_wr.push_back('{a: 4'd3, d: 8'h5A});
        send(8'h5A, 1'b0);
        chk("ptr_after_wr", 32'(O_PTR), 4);
        stop();

        // set ptr 2 then read ACK, NACK
        set_ptr(8'h02);
        start(7'h3C, 1'b1);
        send({7'h3C, 1'b1}, 1'b0);
        rd_chk(8'hA5);
        send(8'hFF, 1'b0);
        rd_chk(8'h5A);
        send(8'hFF, 1'b1);
        chk("ptr_after_nack", 32'(O_PTR), 4);
        chk("ack_skip", 32'(O_ACK), 0);
        send(8'hFF, 1'b0);
        chk("ptr_frozen_skip", 32'(O_PTR), 4);
        stop();

        // wrong address 0x3D: nothing written
        start(7'h3D, 1'b0);
        chk("ack_mismatch", 32'(O_ACK), 0);
        send({7'h3D, 1'b0}, 1'b0);
        send(8'h07, 1'b0);
        chk("ack_mis_skip", 32'(O_ACK), 0);
        send(8'h99, 1'b0);
        chk("ptr_mismatch", 32'(O_PTR), 4);
        stop();

        // upper pointer bits ignored: 0x12 -> 2; registers unchanged
        set_ptr(8'h12);
        chk("ptr_upper_bits", 32'(O_PTR), 2);
        start(7'h3C, 1'b1);
        send({7'h3C, 1'b1}, 1'b0);
        rd_chk(8'hA5);
        send(8'hFF, 1'b0);
        rd_chk(8'h5A);
        send(8'hFF, 1'b1);
        stop();

        // boundary at pointer 15
        start(7'h3C, 1'b0);
        send({7'h3C, 1'b0}, 1'b0);
        send(8'h0F, 1'b0);
        exp_wr.push_back('{a: 4'd15, d: 8'h11});
        send(8'h11, 1'b0);
`ifdef I2C_REG_WRAP_EN
        chk("ack_wrap", 32'(O_ACK), 1);
        exp_wr.push_back('{a: 4'd0, d: 8'h22});
        send(8'h22, 1'b0);
        chk("ptr_wrap", 32'(O_PTR), 1);
`else
        chk("ack_sat", 32'(O_ACK), 0);
        send(8'h22, 1'b0);
        chk("ptr_sat", 32'(O_PTR), 15);
`endif
        stop();
        set_ptr(8'h00);
        start(7'h3C, 1'b1);
        send({7'h3C, 1'b1}, 1'b0);
`ifdef I2C_REG_WRAP_EN
        rd_chk(8'h22);
`else
        rd_chk(8'h00);
`endif
        send(8'hFF, 1'b1);
        stop();

        // reset after ptr byte of a write
        start(7'h3C, 1'b0);
        send({7'h3C, 1'b0}, 1'b0);
        send(8'h03, 1'b0);
        chk("ptr_before_rst", 32'(O_PTR), 3);
        chk("dwr_before_rst", 32'(O_DATA_WR), 32'h5A);
        #2;
        RST_n = 1'b0;
        #1;
        chk("rst_async_ptr", 32'(O_PTR), 0);
        chk("rst_async_dwr", 32'(O_DATA_WR), 0);
        chk("rst_async_stb", 32'(O_WR_STB), 0);
        chk("rst_async_waddr", 32'(O_WR_ADDR), 0);
        chk("rst_async_wdata", 32'(O_WR_DATA), 0);
        chk("rst_async_ack", 32'(O_ACK), 1);
        tick(1);
        RST_n = 1'b1;
        tick(1);
        send(8'h77, 1'b0);
        chk("ptr_after_rst_byte", 32'(O_PTR), 0);
        stop();
        set_ptr(8'h03);
        start(7'h3C, 1'b1);
        send({7'h3C, 1'b1}, 1'b0);
        rd_chk(8'h00);
        send(8'hFF, 1'b1);
        stop();

        tick(3);
        chk("wr_queue_empty", 32'(exp_wr.size()), 0);
        chk("rd_queue_empty", 32'(exp_rd.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/i2c_slv_reg_bank.md
I2C_SLV_REG_BANK -- requirements
Module: i2c_slv_reg_bank

Interface
REQ-001 Parameter DATA_SZ, default 8: data byte width.
REQ-002 Parameter SLV_ADDR, default 7'h3C: 7-bit bus address answered by this bank.
REQ-003 Parameter REG_NUM, default 16: register count, power of two. PTR_SZ = log2(REG_NUM).
REQ-004 CLK  input  1: system clock. All logic is clocked on the rising edge.
REQ-005 RST_n  input  1: asynchronous, active-low reset.
REQ-006 I_BUSY  input  1: slave FSM is inside a transaction.
REQ-007 I_ADDR_SLV  input  DATA_SZ-1: received slave address.
REQ-008 I_RW  input  1: received R/W bit, where 1 = master read.
REQ-009 I_DATA_RD  input  DATA_SZ: byte received from the master.
REQ-010 I_DATA_VL  input  1: one-CLK pulse marking a completed byte.
REQ-011 I_ACK_MSTR  input  1: master ACK bit of the last read byte, where 0 = ACK and 1 = NACK.
REQ-012 O_ACK  output  1: 1 = acknowledge the current byte. Feeds slave I_ACK.
REQ-013 O_DATA_WR  output  DATA_SZ: next byte to transmit to the master.
REQ-014 O_WR_STB  output  1: one-CLK pulse when a register has been written.
REQ-015 O_WR_ADDR  output  PTR_SZ: index of the written register.
REQ-016 O_WR_DATA  output  DATA_SZ: value of the written register.
REQ-017 O_PTR  output  PTR_SZ: current register pointer.

Function
REQ-018 The FSM SHALL have exactly six states: IDLE, ADDR, PTR, WR, RD, SKIP.
REQ-019 IDLE -> ADDR SHALL occur on the rising edge of I_BUSY.
REQ-020 In ADDR, on I_DATA_VL:
- address match and I_RW=0 -> PTR;
- address match and I_RW=1 -> RD;
- mismatch -> SKIP.
REQ-021 In IDLE and ADDR, O_ACK SHALL equal (I_ADDR_SLV == SLV_ADDR), decoded combinationally.
REQ-022 In PTR, on I_DATA_VL: pointer SHALL load I_DATA_RD[PTR_SZ-1:0], and the FSM SHALL go to WR. Upper pointer bits are ignored. O_ACK=1.
REQ-023 In WR, on I_DATA_VL:
- reg[ptr] SHALL load I_DATA_RD;
- O_WR_STB, O_WR_ADDR and O_WR_DATA SHALL be asserted the next cycle;
- the pointer SHALL advance per REQ-031.
REQ-024 In RD, O_DATA_WR SHALL be registered reg[ptr] and valid 1 CLK after entry to RD or after any pointer change.
REQ-025 In RD, on I_DATA_VL: the pointer SHALL advance. If I_ACK_MSTR=1, the FSM SHALL go to SKIP with no further advance.
REQ-026 In SKIP, O_ACK SHALL be 0, and registers and pointer SHALL be frozen.
REQ-027 A falling edge of I_BUSY in any state SHALL return the FSM to IDLE. The pointer is retained, so a following read starts at the last pointer.
REQ-028 An I_DATA_VL in IDLE SHALL be ignored.
REQ-029 If I_BUSY falls in the same cycle as I_DATA_VL, the byte SHALL be processed first, then the FSM goes to IDLE.
REQ-030 A new address phase is recognised only after I_BUSY has been low for at least 1 CLK.
REQ-031 Pointer advance at REG_NUM-1 SHALL follow the Configuration section. Otherwise the pointer increments by 1.

Reset
REQ-032 While RST_n=0, the following SHALL hold immediately, independent of CLK:
- state = IDLE, pointer = 0, all registers = 0;
- O_DATA_WR = 0, O_WR_STB = 0, O_WR_ADDR = 0, O_WR_DATA = 0, O_PTR = 0;
- O_ACK per REQ-021.
REQ-033 A reset asserted mid-transaction SHALL abort it. A partially received byte has no effect. After release, the block waits for a new I_BUSY rising edge.

Configuration
REQ-034 Macro I2C_REG_WRAP_EN defined: the pointer SHALL wrap from REG_NUM-1 to 0, and O_ACK stays 1 in WR.
REQ-035 Macro I2C_REG_WRAP_EN undefined: the pointer SHALL saturate at REG_NUM-1. Any WR byte arriving while saturated after a completed write to REG_NUM-1 SHALL be NACKed (O_ACK=0) and discarded. Reads at saturation repeat reg[REG_NUM-1].

Verification
REQ-036 Write 0x3C/W, ptr 0x02, data 0xA5, 0x5A -> reg2=0xA5, reg3=0x5A; two O_WR_STB pulses with addresses 2 and 3; O_ACK=1 throughout.
REQ-037 Then, after I_BUSY low: 0x3C/R, two bytes, master ACK then NACK -> O_DATA_WR=0xA5 then 0x5A; state SKIP after the NACK; O_PTR=4 (pointer frozen after the NACK).
REQ-038 Address 0x3D -> O_ACK=0, SKIP; following data bytes cause no O_WR_STB; registers unchanged.
REQ-039 Ptr 0x0F, data 0x11, 0x22:
- with I2C_REG_WRAP_EN: reg15=0x11, reg0=0x22;
- without it: reg15=0x11, O_ACK=0 on the second byte, reg0 unchanged.
REQ-040 RST_n pulsed low after the ptr byte of a write -> all outputs 0 immediately; the next data byte without a new I_BUSY rise produces no write.
